// File: rtl/sprite_pkg.sv
// sprite_pkg
//   Shared types and constants for the sprite ROM scheduler slice.
//   SPR_W     : sprite ROM row stride in pixels (largest drawable object edge)
//   ADDR_W    : sprite ROM address width
//   OBJ_NUM   : default number of asteroid objects
//   obj_t     : one object's frame-latched description {x, y, size, act}
//   sched_state_t : frame scheduler states
//   spr_addr  : row/col to ROM address (concatenation when SPR_W is a power of two)
package sprite_pkg;

  localparam int SPR_W     = 32;
  localparam int ADDR_W    = 19;
  localparam int OBJ_NUM   = 4;
  localparam int OBJ_IDX_W = $clog2(OBJ_NUM);
  localparam int SPR_IDX_W = $clog2(SPR_W);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] size;
    logic       act;
  } obj_t;

  typedef enum logic [1:0] {
    WAIT_VS  = 2'd0,
    LATCH    = 2'd1,
    BLANK_VS = 2'd2,
    RUN      = 2'd3
  } sched_state_t;

  // row*SPR_W+col; for a power-of-two stride the product is a plain bit concatenation.
  function automatic logic [ADDR_W-1:0] spr_addr(input logic [SPR_IDX_W-1:0] row,
                                                 input logic [SPR_IDX_W-1:0] col);
    if ((SPR_W & (SPR_W - 1)) == 0)
      return ADDR_W'({row, col});
    else
      return ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/sprite_hit_detect.sv
// sprite_hit_detect
//   Combinational box test of the current pixel against every object plus a fixed
//   priority encoder (index 0 wins).
//   draw_x, draw_y : current pixel coordinate
//   objs           : frame-latched object descriptions
//   hit            : per-object hit vector (active, covered, inside sprite bounds)
//   win            : lowest hit index (0 when nothing hits)
//   any_hit        : at least one object hits
//   multi_hit      : two or more objects hit
//   col, row       : sprite-relative coordinate inside the winning object
module sprite_hit_detect
  import sprite_pkg::*;
#(
  parameter int N     = OBJ_NUM,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [9:0]           draw_x,
  input  logic [9:0]           draw_y,
  input  obj_t                 objs [N],
  output logic [N-1:0]         hit,
  output logic [IDX_W-1:0]     win,
  output logic                 any_hit,
  output logic                 multi_hit,
  output logic [SPR_IDX_W-1:0] col,
  output logic [SPR_IDX_W-1:0] row
);

  logic [SPR_IDX_W-1:0] col_a [N];
  logic [SPR_IDX_W-1:0] row_a [N];

  for (genvar i = 0; i < N; i++) begin : g_obj
    logic [10:0] x_end, y_end, dx, dy;
    logic        in_x, in_y;

    // 11-bit sums so an object hanging past coordinate 1023 does not wrap back to 0.
    // Size 0 makes the range empty, so such an object can never hit.
    assign x_end = {1'b0, objs[i].x} + {1'b0, objs[i].size};
    assign y_end = {1'b0, objs[i].y} + {1'b0, objs[i].size};
    assign dx    = {1'b0, draw_x} - {1'b0, objs[i].x};
    assign dy    = {1'b0, draw_y} - {1'b0, objs[i].y};
    assign in_x  = (draw_x >= objs[i].x) && ({1'b0, draw_x} < x_end);
    assign in_y  = (draw_y >= objs[i].y) && ({1'b0, draw_y} < y_end);

    // Objects larger than the sprite stride are clipped: outside the ROM image is no hit.
    assign hit[i]   = objs[i].act && in_x && in_y && (dx < 11'(SPR_W)) && (dy < 11'(SPR_W));
    assign col_a[i] = dx[SPR_IDX_W-1:0];
    assign row_a[i] = dy[SPR_IDX_W-1:0];
  end

  always_comb begin
    win = '0;
    col = '0;
    row = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win = IDX_W'(i);
        col = col_a[i];
        row = row_a[i];
      end
    end
  end

  assign any_hit   = |hit;
  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign multi_hit = |(hit & (hit - N'(1)));

endmodule

// File: rtl/sprite_rom_scheduler.sv
// sprite_rom_scheduler
//   Per-pixel scheduler for the single shared asteroid sprite ROM port. Each accepted
//   pixel slot picks the highest-priority active object covering (DrawX,DrawY), issues
//   one ROM read and returns the palette index 3 Clk after pix_en, with a strobe.
//   Object state is latched once per frame on the vs falling edge.
//   Clk, Reset_n         : system clock, asynchronous active-low reset
//   pix_en               : one-Clk pixel pulse, samples DrawX/DrawY
//   vs                   : vertical sync, active low
//   DrawX, DrawY         : current pixel coordinate
//   Obj_X/Y/Size/act     : per-object position, edge length, active flag
//   rom_addr, rom_data   : shared sprite ROM port (data valid 1 Clk after address)
//   pix_idx/hit/obj      : palette index, non-transparent hit, winning object
//   pix_strobe           : one-Clk pulse when pix_* are updated
//   overlap              : sticky per frame, two or more objects covered one pixel
module sprite_rom_scheduler
  import sprite_pkg::*;
#(
  parameter int obj_num = OBJ_NUM,
  parameter int IDX_W   = (obj_num > 1) ? $clog2(obj_num) : 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pix_en,
  input  logic              vs,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        Obj_X    [obj_num],
  input  logic [9:0]        Obj_Y    [obj_num],
  input  logic [9:0]        Obj_Size [obj_num],
  input  logic              Obj_act  [obj_num],
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pix_idx,
  output logic              pix_hit,
  output logic [IDX_W-1:0]  pix_obj,
  output logic              pix_strobe,
  output logic              overlap
);

  sched_state_t         state;
  logic                 vs_q;
  logic                 vs_fall, vs_rise;
  logic [obj_num-1:0]   sh_act;
  logic [9:0]           sh_x    [obj_num];
  logic [9:0]           sh_y    [obj_num];
  logic [9:0]           sh_size [obj_num];
  obj_t                 sh_obj  [obj_num];

  logic                 accept_p0;
  logic [obj_num-1:0]   hit_p0;
  logic [IDX_W-1:0]     win_p0;
  logic                 any_hit_p0, multi_hit_p0;
  logic [SPR_IDX_W-1:0] col_p0, row_p0;

  logic                 vld_p1, any_hit_p1;
  logic [IDX_W-1:0]     win_p1;
  logic [SPR_IDX_W-1:0] col_p1, row_p1;

  logic                 vld_p2, any_hit_p2;
  logic [IDX_W-1:0]     win_p2;

  assign vs_fall = vs_q & ~vs;
  assign vs_rise = ~vs_q & vs;

  // A pixel arriving in the same Clk as vs falls belongs to the next frame and is dropped.
  assign accept_p0 = pix_en && (state == RUN) && !vs_fall;

  always_comb begin
    for (int i = 0; i < obj_num; i++) begin
      sh_obj[i].x    = sh_x[i];
      sh_obj[i].y    = sh_y[i];
      sh_obj[i].size = sh_size[i];
      sh_obj[i].act  = sh_act[i];
    end
  end

  // Frame scheduler. vs_q resets low so a vs already low at reset release is not
  // mistaken for a falling edge; drawing resumes only after a full LATCH.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= WAIT_VS;
      vs_q    <= 1'b0;
      sh_act  <= '0;
      overlap <= 1'b0;
    end else begin
      vs_q <= vs;
      case (state)
        WAIT_VS:  if (vs_fall) state <= LATCH;
        LATCH: begin
          for (int i = 0; i < obj_num; i++) sh_act[i] <= Obj_act[i];
          overlap <= 1'b0;
          state   <= BLANK_VS;
        end
        BLANK_VS: if (vs_rise) state <= RUN;
        RUN:      if (vs_fall) state <= LATCH;
        default:  state <= WAIT_VS;
      endcase
      if (accept_p0 && multi_hit_p0) overlap <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (state == LATCH) begin
      for (int i = 0; i < obj_num; i++) begin
        sh_x[i]    <= Obj_X[i];
        sh_y[i]    <= Obj_Y[i];
        sh_size[i] <= Obj_Size[i];
      end
    end
  end

  sprite_hit_detect #(
    .N     (obj_num),
    .IDX_W (IDX_W)
  ) u_hit (
    .draw_x    (DrawX),
    .draw_y    (DrawY),
    .objs      (sh_obj),
    .hit       (hit_p0),
    .win       (win_p0),
    .any_hit   (any_hit_p0),
    .multi_hit (multi_hit_p0),
    .col       (col_p0),
    .row       (row_p0)
  );

  // p0 -> p1: hit decision and sprite-relative coordinate
  always_ff @(posedge Clk) begin
    if (accept_p0) begin
      any_hit_p1 <= any_hit_p0;
      win_p1     <= win_p0;
      col_p1     <= col_p0;
      row_p1     <= row_p0;
    end
  end

  // p1 -> p2: ROM address issue; the address only moves for a pixel that hit
  always_ff @(posedge Clk) begin
    if (vld_p1) begin
      any_hit_p2 <= any_hit_p1;
      win_p2     <= win_p1;
    end
  end

  // p2 -> p3: ROM data capture into the pixel outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      rom_addr   <= '0;
      pix_idx    <= '0;
      pix_hit    <= 1'b0;
      pix_obj    <= '0;
      pix_strobe <= 1'b0;
    end else begin
      vld_p1     <= accept_p0;
      vld_p2     <= vld_p1;
      pix_strobe <= vld_p2;
      if (vld_p1 && any_hit_p1) rom_addr <= spr_addr(row_p1, col_p1);
      if (vld_p2) begin
        pix_idx <= any_hit_p2 ? rom_data : 4'd0;
        pix_hit <= any_hit_p2 && (rom_data != 4'd0);
        pix_obj <= any_hit_p2 ? win_p2 : '0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_scheduler.sv
// tb_sprite_rom_scheduler
//   Directed bench for sprite_rom_scheduler. The sprite ROM is modelled as returning
//   the low nibble of the address, except address 330 which holds palette index 5.
module tb_sprite_rom_scheduler;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        pix_en;
  logic        vs;
  logic [9:0]  DrawX, DrawY;
  logic [9:0]  Obj_X [4];
  logic [9:0]  Obj_Y [4];
  logic [9:0]  Obj_Size [4];
  logic        Obj_act [4];
  logic [18:0] rom_addr;
  logic [3:0]  rom_data;
  logic [3:0]  pix_idx;
  logic        pix_hit;
  logic [1:0]  pix_obj;
  logic        pix_strobe;
  logic        overlap;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 Clk = ~Clk;

  always_comb rom_data = (rom_addr == 19'd330) ? 4'd5 : rom_addr[3:0];

  sprite_rom_scheduler dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .pix_en     (pix_en),
    .vs         (vs),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .Obj_X      (Obj_X),
    .Obj_Y      (Obj_Y),
    .Obj_Size   (Obj_Size),
    .Obj_act    (Obj_act),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pix_idx    (pix_idx),
    .pix_hit    (pix_hit),
    .pix_obj    (pix_obj),
    .pix_strobe (pix_strobe),
    .overlap    (overlap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rom_addr"},   32'(rom_addr),   0);
    chk({tag, ".pix_idx"},    32'(pix_idx),    0);
    chk({tag, ".pix_hit"},    32'(pix_hit),    0);
    chk({tag, ".pix_obj"},    32'(pix_obj),    0);
    chk({tag, ".pix_strobe"}, 32'(pix_strobe), 0);
    chk({tag, ".overlap"},    32'(overlap),    0);
  endtask

  // One pixel: address checked 2 Clk after pix_en, outputs 3 Clk after, strobe gone at 4.
  task automatic px(input string tag, input int x, input int y, input logic es,
                    input int ea, input int ei, input logic eh, input int eo);
    @(negedge Clk);
    DrawX  = 10'(x);
    DrawY  = 10'(y);
    pix_en = 1'b1;
    @(negedge Clk);
    pix_en = 1'b0;
    @(negedge Clk);
    chk({tag, ".rom_addr"}, 32'(rom_addr), ea);
    @(negedge Clk);
    chk({tag, ".strobe"}, 32'(pix_strobe), 32'(es));
    if (es) begin
      chk({tag, ".pix_idx"}, 32'(pix_idx), ei);
      chk({tag, ".pix_hit"}, 32'(pix_hit), 32'(eh));
      chk({tag, ".pix_obj"}, 32'(pix_obj), eo);
    end
    @(negedge Clk);
    chk({tag, ".strobe_end"}, 32'(pix_strobe), 0);
  endtask

  task automatic frame();
    @(negedge Clk);
    vs = 1'b0;
    repeat (3) @(negedge Clk);
    vs = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    logic [2:0] hist;
    int strobes;

    Reset_n = 1'b0;
    pix_en  = 1'b0;
    vs      = 1'b1;
    DrawX   = '0;
    DrawY   = '0;
    Obj_X[0] = 10'd100; Obj_Y[0] = 10'd50;  Obj_Size[0] = 10'd32; Obj_act[0] = 1'b1;
    Obj_X[1] = 10'd115; Obj_Y[1] = 10'd65;  Obj_Size[1] = 10'd20; Obj_act[1] = 1'b1;
    Obj_X[2] = 10'd105; Obj_Y[2] = 10'd55;  Obj_Size[2] = 10'd10; Obj_act[2] = 1'b0;
    Obj_X[3] = 10'd110; Obj_Y[3] = 10'd60;  Obj_Size[3] = 10'd0;  Obj_act[3] = 1'b1;

    repeat (3) @(negedge Clk);
    chk_all_zero("reset");
    Reset_n = 1'b1;

    // No frame latched yet: pixel is ignored.
    px("pre_frame", 110, 60, 1'b0, 0, 0, 1'b0, 0);

    frame();
    px("obj0_basic", 110, 60, 1'b1, 330, 5, 1'b1, 0);
    chk("overlap_clear", 32'(overlap), 0);
    px("right_edge", 132, 60, 1'b1, 330, 0, 1'b0, 0);
    px("overlap_px", 120, 70, 1'b1, 660, 4, 1'b1, 0);
    chk("overlap_set", 32'(overlap), 1);
    px("obj1_only", 133, 70, 1'b1, 178, 2, 1'b1, 1);
    px("transparent", 131, 82, 1'b1, 560, 0, 1'b0, 1);

    // Mid-frame object edits must not take effect until the next latch.
    Obj_X[0] = 10'd200;
    Obj_X[2] = 10'd300; Obj_Y[2] = 10'd300; Obj_Size[2] = 10'd40; Obj_act[2] = 1'b1;
    px("mid_frame_old", 110, 60, 1'b1, 330, 5, 1'b1, 0);
    px("obj2_not_latched", 331, 310, 1'b1, 330, 0, 1'b0, 0);
    chk("overlap_sticky", 32'(overlap), 1);

    frame();
    chk("overlap_new_frame", 32'(overlap), 0);
    px("old_pos", 110, 60, 1'b1, 330, 0, 1'b0, 0);
    px("new_pos", 205, 60, 1'b1, 325, 5, 1'b1, 0);
    px("col_ge_spr_w", 335, 310, 1'b1, 325, 0, 1'b0, 0);
    px("obj2_last_col", 331, 310, 1'b1, 351, 15, 1'b1, 2);

    // vs falls with one pixel in flight and a new pixel in the same Clk.
    @(negedge Clk);
    DrawX  = 10'd205;
    DrawY  = 10'd60;
    pix_en = 1'b1;
    @(negedge Clk);
    vs = 1'b0;
    @(negedge Clk);
    pix_en = 1'b0;
    @(negedge Clk);
    chk("inflight.strobe", 32'(pix_strobe), 1);
    chk("inflight.pix_idx", 32'(pix_idx), 5);
    @(negedge Clk);
    chk("blocked.strobe", 32'(pix_strobe), 0);
    vs = 1'b1;
    repeat (2) @(negedge Clk);

    // Back-to-back pixels: strobe must trail each pix_en by exactly 3 Clk.
    hist    = '0;
    strobes = 0;
    DrawY   = 10'd60;
    for (int k = 0; k < 643; k++) begin
      @(negedge Clk);
      chk("b2b.strobe", 32'(pix_strobe), 32'(hist[2]));
      strobes += int'(pix_strobe);
      pix_en = (k < 640);
      if (k < 640) DrawX = 10'(k);
      hist = {hist[1:0], (k < 640)};
    end
    pix_en = 1'b0;
    chk("b2b.count", 32'(strobes), 640);

    // Reset asserted mid-run while a strobe is showing.
    @(negedge Clk);
    DrawX  = 10'd205;
    pix_en = 1'b1;
    @(negedge Clk);
    pix_en = 1'b0;
    repeat (2) @(negedge Clk);
    chk("pre_reset.strobe", 32'(pix_strobe), 1);
    #2 Reset_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    px("post_reset", 205, 60, 1'b0, 0, 0, 1'b0, 0);
    @(negedge Clk);
    vs = 1'b0;
    repeat (3) @(negedge Clk);
    px("fall_only", 205, 60, 1'b0, 0, 0, 1'b0, 0);
    vs = 1'b1;
    repeat (2) @(negedge Clk);
    px("after_rise", 205, 60, 1'b1, 325, 5, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end of test, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
